// File: rtl/id_stage.sv
// Decode stage: instruction decode, 32x32 register file, load-use hazard stall and ID/EX register.
// Optional write-back to decode bypass is enabled by defining ID_WB_BYPASS_EN.
module id_stage (
  input  logic        clk_i,
  input  logic        n_rst_i,
  input  logic [31:0] IFID_pc_i,
  input  logic [31:0] IFID_ir_i,
  input  logic        MEM_do_branch_i,
  input  logic        WB_we_i,
  input  logic [4:0]  WB_rd_i,
  input  logic [31:0] WB_data_i,
  output logic        ID_stall_o,
  output logic [31:0] IDEX_pc_o,
  output logic [31:0] IDEX_rs_data_o,
  output logic [31:0] IDEX_rt_data_o,
  output logic [31:0] IDEX_imm_o,
  output logic [4:0]  IDEX_rs_o,
  output logic [4:0]  IDEX_rt_o,
  output logic [4:0]  IDEX_rd_o,
  output logic [2:0]  IDEX_alu_op_o,
  output logic        IDEX_alu_src_o,
  output logic        IDEX_reg_write_o,
  output logic        IDEX_mem_read_o,
  output logic        IDEX_mem_write_o,
  output logic        IDEX_branch_o
);

  localparam logic [2:0] AluAdd = 3'd0;
  localparam logic [2:0] AluSub = 3'd1;
  localparam logic [2:0] AluAnd = 3'd2;
  localparam logic [2:0] AluOr  = 3'd3;
  localparam logic [2:0] AluSlt = 3'd4;

  localparam logic [5:0] OpRType = 6'h00;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;
  localparam logic [5:0] OpBeq   = 6'h04;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd_field;

  assign opcode   = IFID_ir_i[31:26];
  assign rs       = IFID_ir_i[25:21];
  assign rt       = IFID_ir_i[20:16];
  assign rd_field = IFID_ir_i[15:11];
  assign funct    = IFID_ir_i[5:0];

  // Decoded control for the instruction currently in ID.
  logic [2:0] dec_alu_op;
  logic       dec_alu_src;
  logic       dec_reg_write;
  logic       dec_mem_read;
  logic       dec_mem_write;
  logic       dec_branch;
  logic [4:0] dec_rd;
  logic       uses_rt;

  always_comb begin
    dec_alu_op    = AluAdd;
    dec_alu_src   = 1'b0;
    dec_reg_write = 1'b0;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_branch    = 1'b0;
    dec_rd        = 5'd0;
    uses_rt       = 1'b0;
    case (opcode)
      OpRType: begin
        uses_rt       = 1'b1;
        dec_reg_write = 1'b1;
        dec_rd        = rd_field;
        case (funct)
          6'h20:   dec_alu_op = AluAdd;
          6'h22:   dec_alu_op = AluSub;
          6'h24:   dec_alu_op = AluAnd;
          6'h25:   dec_alu_op = AluOr;
          6'h2A:   dec_alu_op = AluSlt;
          default: begin
            dec_reg_write = 1'b0;
            dec_rd        = 5'd0;
          end
        endcase
      end
      OpAddi: begin
        dec_alu_src   = 1'b1;
        dec_reg_write = 1'b1;
        dec_rd        = rt;
      end
      OpLw: begin
        dec_alu_src   = 1'b1;
        dec_mem_read  = 1'b1;
        dec_reg_write = 1'b1;
        dec_rd        = rt;
      end
      OpSw: begin
        uses_rt       = 1'b1;
        dec_alu_src   = 1'b1;
        dec_mem_write = 1'b1;
      end
      OpBeq: begin
        uses_rt    = 1'b1;
        dec_alu_op = AluSub;
        dec_branch = 1'b1;
      end
      default: ;
    endcase
  end

  // Register file; r0 is never written so it always reads as zero.
  logic [31:0] rf_q [32];

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= '0;
      end
    end else if (WB_we_i && (WB_rd_i != 5'd0)) begin
      rf_q[WB_rd_i] <= WB_data_i;
    end
  end

  logic [31:0] rs_data;
  logic [31:0] rt_data;

  always_comb begin
    rs_data = (rs == 5'd0) ? 32'd0 : rf_q[rs];
    rt_data = (rt == 5'd0) ? 32'd0 : rf_q[rt];
`ifdef ID_WB_BYPASS_EN
    if (WB_we_i && (WB_rd_i != 5'd0) && (WB_rd_i == rs)) rs_data = WB_data_i;
    if (WB_we_i && (WB_rd_i != 5'd0) && (WB_rd_i == rt)) rt_data = WB_data_i;
`endif
  end

  // ID/EX pipeline register.
  logic [31:0] pc_q, rs_data_q, rt_data_q, imm_q;
  logic [4:0]  rs_q, rt_q, rd_q;
  logic [2:0]  alu_op_q;
  logic        alu_src_q, reg_write_q, mem_read_q, mem_write_q, branch_q;

  logic [31:0] imm_d;
  logic [4:0]  rd_d;
  logic [2:0]  alu_op_d;
  logic        alu_src_d, reg_write_d, mem_read_d, mem_write_d, branch_d;
  logic        stall;
  logic        bubble;

  // A flush overrides the stall so IF is free to load the branch target.
  always_comb begin
    stall = mem_read_q && (rd_q != 5'd0) && !MEM_do_branch_i &&
            ((rd_q == rs) || (uses_rt && (rd_q == rt)));
  end

  assign bubble = MEM_do_branch_i || stall;
  assign imm_d  = {{16{IFID_ir_i[15]}}, IFID_ir_i[15:0]};

  always_comb begin
    alu_op_d    = dec_alu_op;
    alu_src_d   = dec_alu_src;
    reg_write_d = dec_reg_write;
    mem_read_d  = dec_mem_read;
    mem_write_d = dec_mem_write;
    branch_d    = dec_branch;
    rd_d        = dec_rd;
    if (bubble) begin
      alu_op_d    = AluAdd;
      alu_src_d   = 1'b0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      branch_d    = 1'b0;
      rd_d        = 5'd0;
    end
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      pc_q        <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      alu_op_q    <= '0;
      alu_src_q   <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      branch_q    <= 1'b0;
    end else begin
      pc_q        <= IFID_pc_i;
      rs_data_q   <= rs_data;
      rt_data_q   <= rt_data;
      imm_q       <= imm_d;
      rs_q        <= rs;
      rt_q        <= rt;
      rd_q        <= rd_d;
      alu_op_q    <= alu_op_d;
      alu_src_q   <= alu_src_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      branch_q    <= branch_d;
    end
  end

  assign ID_stall_o       = stall;
  assign IDEX_pc_o        = pc_q;
  assign IDEX_rs_data_o   = rs_data_q;
  assign IDEX_rt_data_o   = rt_data_q;
  assign IDEX_imm_o       = imm_q;
  assign IDEX_rs_o        = rs_q;
  assign IDEX_rt_o        = rt_q;
  assign IDEX_rd_o        = rd_q;
  assign IDEX_alu_op_o    = alu_op_q;
  assign IDEX_alu_src_o   = alu_src_q;
  assign IDEX_reg_write_o = reg_write_q;
  assign IDEX_mem_read_o  = mem_read_q;
  assign IDEX_mem_write_o = mem_write_q;
  assign IDEX_branch_o    = branch_q;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: expected ID/EX contents are queued at drive time
// and compared after the capturing edge.
module tb_id_stage;

  logic        clk_i = 1'b0;
  logic        n_rst_i;
  logic [31:0] IFID_pc_i, IFID_ir_i, WB_data_i;
  logic        MEM_do_branch_i, WB_we_i;
  logic [4:0]  WB_rd_i;
  logic        ID_stall_o;
  logic [31:0] IDEX_pc_o, IDEX_rs_data_o, IDEX_rt_data_o, IDEX_imm_o;
  logic [4:0]  IDEX_rs_o, IDEX_rt_o, IDEX_rd_o;
  logic [2:0]  IDEX_alu_op_o;
  logic        IDEX_alu_src_o, IDEX_reg_write_o, IDEX_mem_read_o, IDEX_mem_write_o;
  logic        IDEX_branch_o;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [2:0]  alu_op;
    logic        alu_src;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
  } exp_t;

  exp_t obs;
  exp_t sb[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fails  = 0;

  id_stage dut (
    .clk_i            (clk_i),
    .n_rst_i          (n_rst_i),
    .IFID_pc_i        (IFID_pc_i),
    .IFID_ir_i        (IFID_ir_i),
    .MEM_do_branch_i  (MEM_do_branch_i),
    .WB_we_i          (WB_we_i),
    .WB_rd_i          (WB_rd_i),
    .WB_data_i        (WB_data_i),
    .ID_stall_o       (ID_stall_o),
    .IDEX_pc_o        (IDEX_pc_o),
    .IDEX_rs_data_o   (IDEX_rs_data_o),
    .IDEX_rt_data_o   (IDEX_rt_data_o),
    .IDEX_imm_o       (IDEX_imm_o),
    .IDEX_rs_o        (IDEX_rs_o),
    .IDEX_rt_o        (IDEX_rt_o),
    .IDEX_rd_o        (IDEX_rd_o),
    .IDEX_alu_op_o    (IDEX_alu_op_o),
    .IDEX_alu_src_o   (IDEX_alu_src_o),
    .IDEX_reg_write_o (IDEX_reg_write_o),
    .IDEX_mem_read_o  (IDEX_mem_read_o),
    .IDEX_mem_write_o (IDEX_mem_write_o),
    .IDEX_branch_o    (IDEX_branch_o)
  );

  always #5 clk_i = ~clk_i;

  assign obs = {IDEX_pc_o, IDEX_rs_data_o, IDEX_rt_data_o, IDEX_imm_o, IDEX_rs_o, IDEX_rt_o,
                IDEX_rd_o, IDEX_alu_op_o, IDEX_alu_src_o, IDEX_reg_write_o, IDEX_mem_read_o,
                IDEX_mem_write_o, IDEX_branch_o};

  function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] rsd,
                              input logic [31:0] rtd, input logic [31:0] imm,
                              input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                              input logic [2:0] op, input logic src, input logic rw,
                              input logic mr, input logic mw, input logic br);
    exp_t x;
    x = '{pc: pc, rs_data: rsd, rt_data: rtd, imm: imm, rs: rs, rt: rt, rd: rd, alu_op: op,
          alu_src: src, reg_write: rw, mem_read: mr, mem_write: mw, branch: br};
    return x;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [31:0] ir, input logic [31:0] pc);
    IFID_ir_i = ir;
    IFID_pc_i = pc;
  endtask

  task automatic wb_write(input logic [4:0] rd, input logic [31:0] data);
    drive(32'h0, 32'h0);
    WB_we_i   = 1'b1;
    WB_rd_i   = rd;
    WB_data_i = data;
    tick();
    WB_we_i   = 1'b0;
  endtask

  task automatic test_reset();
    n_rst_i = 1'b0;
    drive(32'h0, 32'h0);
    MEM_do_branch_i = 1'b0;
    WB_we_i = 1'b0; WB_rd_i = '0; WB_data_i = '0;
    #3;
    n_checks++;
    if (obs !== exp_t'(0)) begin
      $display("FAIL reset_outputs got=%h want=0", obs); n_fails++;
    end
    n_checks++;
    if (ID_stall_o !== 1'b0) begin
      $display("FAIL reset_stall got=%b want=0", ID_stall_o); n_fails++;
    end
    #4 n_rst_i = 1'b1;
    tick();
    drive(32'h0, 32'h4);
    sb.push_back(mk(32'h4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick();
    e = sb.pop_front();
    n_checks++;
    if (obs !== e) begin
      $display("FAIL post_reset_nop got=%h want=%h", obs, e); n_fails++;
    end
    n_checks++;
    if (ID_stall_o !== 1'b0) begin
      $display("FAIL post_reset_stall got=%b want=0", ID_stall_o); n_fails++;
    end
  endtask

  task automatic test_rtype();
    wb_write(5'd5, 32'h1234);
    wb_write(5'd0, 32'hFFFF);
    drive(32'h00A01820, 32'h10);
    sb.push_back(mk(32'h10, 32'h1234, 0, 32'h1820, 5, 0, 3, 0, 0, 1, 0, 0, 0));
    tick();
    e = sb.pop_front();
    n_checks++;
    if (obs !== e) begin
      $display("FAIL add_r3_r5_r0 got=%h want=%h", obs, e); n_fails++;
    end
  endtask

  task automatic test_decode_table();
    logic [31:0] irs [7];
    exp_t        exps [7];
    wb_write(5'd1, 32'h100);
    wb_write(5'd2, 32'h22);
    irs[0] = 32'h00222022; exps[0] = mk(32'h20, 32'h100, 32'h22, 32'h2022, 1, 2, 4, 1, 0, 1, 0, 0, 0);
    irs[1] = 32'h00222024; exps[1] = mk(32'h24, 32'h100, 32'h22, 32'h2024, 1, 2, 4, 2, 0, 1, 0, 0, 0);
    irs[2] = 32'h00222025; exps[2] = mk(32'h28, 32'h100, 32'h22, 32'h2025, 1, 2, 4, 3, 0, 1, 0, 0, 0);
    irs[3] = 32'h0022202A; exps[3] = mk(32'h2C, 32'h100, 32'h22, 32'h202A, 1, 2, 4, 4, 0, 1, 0, 0, 0);
    irs[4] = 32'h00222021; exps[4] = mk(32'h30, 32'h100, 32'h22, 32'h2021, 1, 2, 0, 0, 0, 0, 0, 0, 0);
    irs[5] = 32'hAC220010; exps[5] = mk(32'h34, 32'h100, 32'h22, 32'h0010, 1, 2, 0, 0, 1, 0, 0, 1, 0);
    irs[6] = 32'h10220003; exps[6] = mk(32'h38, 32'h100, 32'h22, 32'h0003, 1, 2, 0, 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 7; i++) begin
      drive(irs[i], 32'h20 + 32'(4 * i));
      sb.push_back(exps[i]);
      tick();
      e = sb.pop_front();
      n_checks++;
      if (obs !== e) begin
        $display("FAIL decode[%0d] got=%h want=%h", i, obs, e); n_fails++;
      end
    end
  endtask

  task automatic test_load_use();
    drive(32'h8C220008, 32'h40);
    #1;
    n_checks++;
    if (ID_stall_o !== 1'b0) begin
      $display("FAIL lu_no_stall_on_lw got=%b want=0", ID_stall_o); n_fails++;
    end
    sb.push_back(mk(32'h40, 32'h100, 32'h22, 8, 1, 2, 2, 0, 1, 1, 1, 0, 0));
    tick();
    e = sb.pop_front();
    n_checks++;
    if (obs !== e) begin $display("FAIL lu_lw got=%h want=%h", obs, e); n_fails++; end
    drive(32'h00422020, 32'h44);
    #1;
    n_checks++;
    if (ID_stall_o !== 1'b1) begin
      $display("FAIL lu_stall got=%b want=1", ID_stall_o); n_fails++;
    end
    sb.push_back(mk(32'h44, 32'h22, 32'h22, 32'h2020, 2, 2, 0, 0, 0, 0, 0, 0, 0));
    sb.push_back(mk(32'h44, 32'h22, 32'h22, 32'h2020, 2, 2, 4, 0, 0, 1, 0, 0, 0));
    tick();
    e = sb.pop_front();
    n_checks++;
    if (obs !== e) begin $display("FAIL lu_bubble got=%h want=%h", obs, e); n_fails++; end
    n_checks++;
    if (ID_stall_o !== 1'b0) begin
      $display("FAIL lu_stall_release got=%b want=0", ID_stall_o); n_fails++;
    end
    tick();
    e = sb.pop_front();
    n_checks++;
    if (obs !== e) begin $display("FAIL lu_add_issue got=%h want=%h", obs, e); n_fails++; end
  endtask

  task automatic test_hazard_operands();
    wb_write(5'd3, 32'h33);
    // lw r2 then sw r2: rt use must stall.
    drive(32'h8C220008, 32'h50);
    tick();
    drive(32'hAC220010, 32'h54);
    #1;
    n_checks++;
    if (ID_stall_o !== 1'b1) begin
      $display("FAIL sw_rt_stall got=%b want=1", ID_stall_o); n_fails++;
    end
    tick();
    tick();
    // lw r2 then addi r2,r3,1: rt is a destination, not a use.
    drive(32'h8C220008, 32'h58);
    tick();
    drive(32'h20620001, 32'h5C);
    #1;
    n_checks++;
    if (ID_stall_o !== 1'b0) begin
      $display("FAIL addi_rt_no_stall got=%b want=0", ID_stall_o); n_fails++;
    end
    sb.push_back(mk(32'h5C, 32'h33, 32'h22, 1, 3, 2, 2, 0, 1, 1, 0, 0, 0));
    tick();
    e = sb.pop_front();
    n_checks++;
    if (obs !== e) begin $display("FAIL addi_issue got=%h want=%h", obs, e); n_fails++; end
    // lw r0 then add r4,r0,r0: destination r0 never stalls.
    drive(32'h8C200008, 32'h60);
    sb.push_back(mk(32'h60, 32'h100, 0, 8, 1, 0, 0, 0, 1, 1, 1, 0, 0));
    tick();
    e = sb.pop_front();
    n_checks++;
    if (obs !== e) begin $display("FAIL lw_r0 got=%h want=%h", obs, e); n_fails++; end
    drive(32'h00002020, 32'h64);
    #1;
    n_checks++;
    if (ID_stall_o !== 1'b0) begin
      $display("FAIL r0_no_stall got=%b want=0", ID_stall_o); n_fails++;
    end
    tick();
  endtask

  task automatic test_flush();
    drive(32'h8C220008, 32'h80);
    tick();
    drive(32'h00422020, 32'h84);
    MEM_do_branch_i = 1'b1;
    #1;
    n_checks++;
    if (ID_stall_o !== 1'b0) begin
      $display("FAIL flush_stall got=%b want=0", ID_stall_o); n_fails++;
    end
    sb.push_back(mk(32'h84, 32'h22, 32'h22, 32'h2020, 2, 2, 0, 0, 0, 0, 0, 0, 0));
    tick();
    MEM_do_branch_i = 1'b0;
    e = sb.pop_front();
    n_checks++;
    if (obs !== e) begin $display("FAIL flush_bubble got=%h want=%h", obs, e); n_fails++; end
    sb.push_back(mk(32'h84, 32'h22, 32'h22, 32'h2020, 2, 2, 4, 0, 0, 1, 0, 0, 0));
    tick();
    e = sb.pop_front();
    n_checks++;
    if (obs !== e) begin $display("FAIL flush_next got=%h want=%h", obs, e); n_fails++; end
  endtask

  task automatic test_bypass();
    logic [31:0] want_rs;
    wb_write(5'd7, 32'h1111);
`ifdef ID_WB_BYPASS_EN
    want_rs = 32'hCAFE;
`else
    want_rs = 32'h1111;
`endif
    drive(32'h00E04020, 32'h90);
    WB_we_i = 1'b1; WB_rd_i = 5'd7; WB_data_i = 32'hCAFE;
    sb.push_back(mk(32'h90, want_rs, 0, 32'h4020, 7, 0, 8, 0, 0, 1, 0, 0, 0));
    tick();
    WB_we_i = 1'b0;
    e = sb.pop_front();
    n_checks++;
    if (obs !== e) begin $display("FAIL same_cycle_r7 got=%h want=%h", obs, e); n_fails++; end
    sb.push_back(mk(32'h90, 32'hCAFE, 0, 32'h4020, 7, 0, 8, 0, 0, 1, 0, 0, 0));
    tick();
    e = sb.pop_front();
    n_checks++;
    if (obs !== e) begin $display("FAIL later_r7 got=%h want=%h", obs, e); n_fails++; end
    drive(32'h00004020, 32'h94);
    WB_we_i = 1'b1; WB_rd_i = 5'd0; WB_data_i = 32'hDEAD;
    sb.push_back(mk(32'h94, 0, 0, 32'h4020, 0, 0, 8, 0, 0, 1, 0, 0, 0));
    tick();
    WB_we_i = 1'b0;
    e = sb.pop_front();
    n_checks++;
    if (obs !== e) begin $display("FAIL r0_write_bypass got=%h want=%h", obs, e); n_fails++; end
  endtask

  task automatic test_addi_bubble();
    drive(32'h2009FFFC, 32'hA0);
    sb.push_back(mk(32'hA0, 0, 0, 32'hFFFFFFFC, 0, 9, 9, 0, 1, 1, 0, 0, 0));
    tick();
    e = sb.pop_front();
    n_checks++;
    if (obs !== e) begin $display("FAIL addi_neg got=%h want=%h", obs, e); n_fails++; end
    drive(32'hFC221234, 32'hA4);
    sb.push_back(mk(32'hA4, 32'h100, 32'h22, 32'h1234, 1, 2, 0, 0, 0, 0, 0, 0, 0));
    tick();
    e = sb.pop_front();
    n_checks++;
    if (obs !== e) begin $display("FAIL opcode_3f got=%h want=%h", obs, e); n_fails++; end
  endtask

  task automatic test_reset_mid_stall();
    drive(32'h8C220008, 32'hB0);
    tick();
    drive(32'h00422020, 32'hB4);
    #1;
    n_checks++;
    if (ID_stall_o !== 1'b1) begin
      $display("FAIL pre_reset_stall got=%b want=1", ID_stall_o); n_fails++;
    end
    n_rst_i = 1'b0;
    #1;
    n_checks++;
    if (ID_stall_o !== 1'b0) begin
      $display("FAIL mid_reset_stall got=%b want=0", ID_stall_o); n_fails++;
    end
    n_checks++;
    if (obs !== exp_t'(0)) begin
      $display("FAIL mid_reset_outputs got=%h want=0", obs); n_fails++;
    end
    #1 n_rst_i = 1'b1;
    drive(32'h00A01820, 32'hB8);
    sb.push_back(mk(32'hB8, 0, 0, 32'h1820, 5, 0, 3, 0, 0, 1, 0, 0, 0));
    tick();
    e = sb.pop_front();
    n_checks++;
    if (obs !== e) begin $display("FAIL rf_cleared got=%h want=%h", obs, e); n_fails++; end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_decode_table();
    test_load_use();
    test_hazard_operands();
    test_flush();
    test_bypass();
    test_addi_bubble();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
